game_flow_ctrl: RTL and testbench

Parametrised game-flow state machine for the tilt-ball game. Generalises the single-mode top-level controller: adds CLASSIC mode with lives and a level count, ENDLESS mode with a level counter, a load-timeout recovery, per-state menu sizing and the selection cursor. Sits between the debounced and pulsed buttons and the level generator, ball mover, drop detector and screen controller.

---
 rtl/game_flow_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game-flow state machine for the tilt-ball game.
// CLASSIC mode counts lives and stops after NUM_LEVELS cleared levels;
// ENDLESS mode counts levels without limit. A watchdog in LOAD retries
// the level generator when its outputs never become ready.
// Build option: define SEL_WRAP_EN to make the menu cursor wrap at both ends
// (default build saturates the cursor).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MENU     | main menu, sel0 = CLASSIC, sel1 = ENDLESS
// PLAYING  | ball is live
// FAIL     | ball fell in a fail hole; retry or menu
// WIN      | ball reached the win hole; next level or menu
// LOAD     | waiting for level generator and accelerometer
// AGAIN    | one-cycle ball/drop reset before replaying the same level
// BALL_RST | one-cycle ball/drop reset after a fresh level load
// PAUSE    | pause menu (resume/retry/[new level]/menu)
// NEW_RST  | one-cycle level generator restart
// OVER     | game finished (out of lives or all levels cleared)
module game_flow_ctrl #(
    parameter int NUM_LEVELS   = 5,
    parameter int LEVEL_W      = 4,
    parameter int MAX_LIVES    = 3,
    parameter int LIVES_W      = 3,
    parameter int LOAD_TIMEOUT = 1000000,
    parameter int TMO_W        = 20
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               ok_pulse,
    input  logic               up_pulse,
    input  logic               down_pulse,
    input  logic               pos_ready,
    input  logic               accel_ready,
    input  logic               playing_win,
    input  logic               playing_fail,
    output logic [3:0]         state,
    output logic               game_mode,
    output logic [2:0]         select_pos,
    output logic [2:0]         max_option,
    output logic               level_gen_rst,
    output logic               latch_level,
    output logic               ball_rst,
    output logic               drop_rst,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic               game_won,
    output logic               load_err
);

    typedef enum logic [3:0] {
        S_MENU     = 4'd0,
        S_PLAYING  = 4'd1,
        S_FAIL     = 4'd2,
        S_WIN      = 4'd3,
        S_LOAD     = 4'd4,
        S_AGAIN    = 4'd5,
        S_BALL_RST = 4'd6,
        S_PAUSE    = 4'd7,
        S_NEW_RST  = 4'd8,
        S_OVER     = 4'd9
    } state_t;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOAD_TIMEOUT - 1);

    // game_mode encoding: 0 = CLASSIC, 1 = ENDLESS
    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [2:0]         sel_q, sel_d;
    logic [2:0]         max_opt;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               won_q, won_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    // State and game-progress registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_MENU;
            mode_q  <= 1'b1;
            sel_q   <= '0;
            level_q <= '0;
            lives_q <= LIVES_INIT;
            won_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            level_q <= level_d;
            lives_q <= lives_d;
            won_q   <= won_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state, counters, one-cycle pulses and menu cursor.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        sel_d         = sel_q;
        level_d       = level_q;
        lives_d       = lives_q;
        won_d         = won_q;
        err_d         = err_q;
        tmo_d         = tmo_q;
        level_gen_rst = 1'b0;
        latch_level   = 1'b0;
        ball_rst      = 1'b0;
        drop_rst      = 1'b0;

        case (state_q)
            S_MENU, S_FAIL, S_WIN: max_opt = 3'd2;
            S_PAUSE:               max_opt = mode_q ? 3'd4 : 3'd3;
            default:               max_opt = 3'd0;
        endcase

        case (state_q)
            S_MENU: begin
                if (ok_pulse) begin
                    state_d = S_NEW_RST;
                    mode_d  = (sel_q != 3'd0);
                    level_d = '0;
                    lives_d = LIVES_INIT;
                    won_d   = 1'b0;
                end
            end
            S_NEW_RST: begin
                level_gen_rst = 1'b1;
                drop_rst      = 1'b1;
                tmo_d         = '0;
                state_d       = S_LOAD;
            end
            S_LOAD: begin
                if (pos_ready && accel_ready) begin
                    latch_level = 1'b1;
                    state_d     = S_BALL_RST;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_NEW_RST;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_BALL_RST, S_AGAIN: begin
                ball_rst = 1'b1;
                drop_rst = 1'b1;
                state_d  = S_PLAYING;
            end
            S_PLAYING: begin
                if (playing_fail) begin
                    state_d = S_FAIL;
                    if (!mode_q && lives_q != '0)
                        lives_d = lives_q - 1'b1;
                end else if (playing_win) begin
                    if (level_q != LEVEL_MAX)
                        level_d = level_q + 1'b1;
                    if (!mode_q && level_q == LAST_LEVEL) begin
                        won_d   = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        state_d = S_WIN;
                    end
                end else if (ok_pulse) begin
                    state_d = S_PAUSE;
                end
            end
            S_FAIL: begin
                if (!mode_q && lives_q == '0)
                    state_d = S_OVER;
                else if (ok_pulse)
                    state_d = (sel_q == 3'd0) ? S_AGAIN : S_MENU;
            end
            S_WIN: begin
                if (ok_pulse)
                    state_d = (sel_q == 3'd0) ? S_NEW_RST : S_MENU;
            end
            S_PAUSE: begin
                if (ok_pulse) begin
                    case (sel_q)
                        3'd0:    state_d = S_PLAYING;
                        3'd1:    state_d = S_AGAIN;
                        3'd2:    state_d = mode_q ? S_NEW_RST : S_MENU;
                        default: state_d = S_MENU;
                    endcase
                end
            end
            S_OVER: begin
                if (ok_pulse)
                    state_d = S_MENU;
            end
            default: state_d = S_MENU;
        endcase

        // Cursor restarts at the top of every newly entered menu.
        if (state_d != state_q || ok_pulse) begin
            sel_d = '0;
        end else if (up_pulse && !down_pulse) begin
            if (sel_q != 3'd0)
                sel_d = sel_q - 3'd1;
`ifdef SEL_WRAP_EN
            else if (max_opt != 3'd0)
                sel_d = max_opt - 3'd1;
`endif
        end else if (down_pulse && !up_pulse) begin
            if (max_opt != 3'd0 && sel_q < max_opt - 3'd1)
                sel_d = sel_q + 3'd1;
`ifdef SEL_WRAP_EN
            else if (max_opt != 3'd0)
                sel_d = 3'd0;
`endif
        end
    end

    assign state      = state_q;
    assign game_mode  = mode_q;
    assign select_pos = sel_q;
    assign max_option = max_opt;
    assign level      = level_q;
    assign lives      = lives_q;
    assign game_won   = won_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a randomized run
// compared against a behavioural model of the game rules.
module tb_game_flow_ctrl;

    localparam int NL = 5;
    localparam int LW = 4;
    localparam int ML = 3;
    localparam int VW = 3;
    localparam int LT = 16;
    localparam int TW = 5;

    localparam int MENU = 0, PLAY = 1, FAILS = 2, WIN = 3, LOAD = 4, AGAIN = 5;
    localparam int BALL = 6, PAUSE = 7, NEWR = 8, OVER = 9;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic          ok_pulse = 1'b0, up_pulse = 1'b0, down_pulse = 1'b0;
    logic          pos_ready = 1'b0, accel_ready = 1'b0;
    logic          playing_win = 1'b0, playing_fail = 1'b0;
    logic [3:0]    state;
    logic          game_mode;
    logic [2:0]    select_pos, max_option;
    logic          level_gen_rst, latch_level, ball_rst, drop_rst;
    logic [LW-1:0] level;
    logic [VW-1:0] lives;
    logic          game_won, load_err;

    game_flow_ctrl #(
        .NUM_LEVELS(NL), .LEVEL_W(LW), .MAX_LIVES(ML), .LIVES_W(VW),
        .LOAD_TIMEOUT(LT), .TMO_W(TW)
    ) dut (
        .CLK(CLK), .rst(rst),
        .ok_pulse(ok_pulse), .up_pulse(up_pulse), .down_pulse(down_pulse),
        .pos_ready(pos_ready), .accel_ready(accel_ready),
        .playing_win(playing_win), .playing_fail(playing_fail),
        .state(state), .game_mode(game_mode), .select_pos(select_pos),
        .max_option(max_option), .level_gen_rst(level_gen_rst),
        .latch_level(latch_level), .ball_rst(ball_rst), .drop_rst(drop_rst),
        .level(level), .lives(lives), .game_won(game_won), .load_err(load_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the game rules
    int m_state = MENU, m_sel = 0, m_level = 0, m_lives = ML, m_tmo = 0;
    bit m_mode = 1'b1, m_won = 1'b0, m_err = 1'b0;
    logic [3:0] p_dut, p_exp;

    function automatic int opts(int st, bit md);
        if (st == MENU || st == FAILS || st == WIN) return 2;
        if (st == PAUSE) return md ? 4 : 3;
        return 0;
    endfunction

    function automatic logic [19:0] mvec();
        return {4'(m_state), m_mode, 3'(m_sel), 3'(opts(m_state, m_mode)),
                4'(m_level), 3'(m_lives), m_won, m_err};
    endfunction

    function automatic logic [19:0] dvec();
        return {state, game_mode, select_pos, max_option, level, lives, game_won, load_err};
    endfunction

    task automatic model_pulses();
        p_exp[3] = (m_state == NEWR);
        p_exp[2] = (m_state == LOAD) && pos_ready && accel_ready;
        p_exp[1] = (m_state == BALL) || (m_state == AGAIN);
        p_exp[0] = (m_state == NEWR) || (m_state == BALL) || (m_state == AGAIN);
    endtask

    task automatic model_clock();
        int nxt, mx, pre;
        if (rst) begin
            m_state = MENU; m_mode = 1'b1; m_sel = 0; m_level = 0;
            m_lives = ML; m_won = 1'b0; m_err = 1'b0; m_tmo = 0;
            return;
        end
        nxt = m_state;
        mx  = opts(m_state, m_mode);
        if (m_state == MENU) begin
            if (ok_pulse) begin
                nxt = NEWR; m_mode = (m_sel != 0); m_level = 0; m_lives = ML; m_won = 1'b0;
            end
        end else if (m_state == NEWR) begin
            nxt = LOAD; m_tmo = 0;
        end else if (m_state == LOAD) begin
            if (pos_ready && accel_ready) nxt = BALL;
            else if (m_tmo == LT - 1) begin m_err = 1'b1; nxt = NEWR; end
            else m_tmo++;
        end else if (m_state == BALL || m_state == AGAIN) begin
            nxt = PLAY;
        end else if (m_state == PLAY) begin
            if (playing_fail) begin
                nxt = FAILS;
                if (!m_mode && m_lives > 0) m_lives--;
            end else if (playing_win) begin
                pre = m_level;
                if (m_level < (1 << LW) - 1) m_level++;
                if (!m_mode && pre == NL - 1) begin m_won = 1'b1; nxt = OVER; end
                else nxt = WIN;
            end else if (ok_pulse) nxt = PAUSE;
        end else if (m_state == FAILS) begin
            if (!m_mode && m_lives == 0) nxt = OVER;
            else if (ok_pulse) nxt = (m_sel == 0) ? AGAIN : MENU;
        end else if (m_state == WIN) begin
            if (ok_pulse) nxt = (m_sel == 0) ? NEWR : MENU;
        end else if (m_state == PAUSE) begin
            if (ok_pulse) begin
                if (m_sel == 0) nxt = PLAY;
                else if (m_sel == 1) nxt = AGAIN;
                else if (m_sel == 2 && m_mode) nxt = NEWR;
                else nxt = MENU;
            end
        end else if (m_state == OVER) begin
            if (ok_pulse) nxt = MENU;
        end
        if (nxt != m_state || ok_pulse) m_sel = 0;
        else if (up_pulse && !down_pulse) begin
            if (m_sel > 0) m_sel--;
`ifdef SEL_WRAP_EN
            else if (mx > 0) m_sel = mx - 1;
`endif
        end else if (down_pulse && !up_pulse) begin
            if (m_sel < mx - 1) m_sel++;
`ifdef SEL_WRAP_EN
            else if (mx > 0) m_sel = 0;
`endif
        end
        m_state = nxt;
    endtask

    // One clock: drive inputs, sample pulses mid-cycle, advance model after the edge.
    task automatic step(input bit ok, input bit up, input bit dn, input bit pr,
                        input bit ar, input bit win, input bit fl);
        ok_pulse = ok; up_pulse = up; down_pulse = dn;
        pos_ready = pr; accel_ready = ar; playing_win = win; playing_fail = fl;
        model_pulses();
        #1;
        p_dut = {level_gen_rst, latch_level, ball_rst, drop_rst};
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // NEW_RST -> LOAD (random wait) -> BALL_RST -> PLAYING
    task automatic start_level();
        int w;
        w = $urandom_range(0, 3);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < w; k++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (game_mode !== 1'b1) begin failures++; $display("FAIL rst_mode got=%0d exp=1", game_mode); end
        checks++; if (select_pos !== 3'd0) begin failures++; $display("FAIL rst_sel got=%0d exp=0", select_pos); end
        checks++; if (lives !== 3'd3 || level !== 4'd0) begin failures++; $display("FAIL rst_counts got lives=%0d level=%0d exp 3,0", lives, level); end
        checks++; if (game_won !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL rst_flags got won=%0d err=%0d exp 0,0", game_won, load_err); end
        checks++; if (max_option !== 3'd2) begin failures++; $display("FAIL rst_maxopt got=%0d exp=2", max_option); end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++; if (p_dut !== 4'b0000) begin failures++; $display("FAIL rst_pulses got=%b exp=0000", p_dut); end
    endtask

    task automatic test_cursor();
        bit         ups [7] = '{0, 1, 1, 0, 1, 1, 1};
        bit         dns [7] = '{1, 0, 0, 1, 1, 0, 0};
`ifdef SEL_WRAP_EN
        logic [2:0] exps[7] = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0};
`else
        logic [2:0] exps[7] = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
`endif
        for (int i = 0; i < 7; i++) begin
            step(0, ups[i], dns[i], 0, 0, 0, 0);
            checks++; if (select_pos !== exps[i]) begin failures++; $display("FAIL cursor_%0d got=%0d exp=%0d", i, select_pos, exps[i]); end
        end
    endtask

    task automatic test_classic_start();
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (state !== 4'd8 || game_mode !== 1'b0) begin failures++; $display("FAIL start_newrst got st=%0d mode=%0d exp 8,0", state, game_mode); end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++; if (p_dut !== 4'b1001 || state !== 4'd4) begin failures++; $display("FAIL start_lgr got p=%b st=%0d exp 1001,4", p_dut, state); end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        checks++; if (state !== 4'd4 || p_dut !== 4'b0000) begin failures++; $display("FAIL start_wait got st=%0d p=%b exp 4,0000", state, p_dut); end
        step(0, 0, 0, 1, 1, 0, 0);
        checks++; if (p_dut !== 4'b0100 || state !== 4'd6) begin failures++; $display("FAIL start_latch got p=%b st=%0d exp 0100,6", p_dut, state); end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++; if (p_dut !== 4'b0011 || state !== 4'd1) begin failures++; $display("FAIL start_ballrst got p=%b st=%0d exp 0011,1", p_dut, state); end
        checks++; if (lives !== 3'd3 || level !== 4'd0) begin failures++; $display("FAIL start_counts got lives=%0d level=%0d exp 3,0", lives, level); end
    endtask

    task automatic test_classic_fail();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            checks++; if (state !== 4'd2 || lives !== 3'(2 - i)) begin failures++; $display("FAIL fail_%0d got st=%0d lives=%0d exp 2,%0d", i, state, lives, 2 - i); end
            if (i < 2) begin
                step(1, 0, 0, 0, 0, 0, 0);
                checks++; if (state !== 4'd5) begin failures++; $display("FAIL fail_again_%0d got=%0d exp=5", i, state); end
                step(0, 0, 0, 0, 0, 0, 0);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++; if (state !== 4'd9) begin failures++; $display("FAIL fail_over got=%0d exp=9", state); end
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL fail_menu got=%0d exp=0", state); end
    endtask

    task automatic test_classic_win();
        step(1, 0, 0, 0, 0, 0, 0);
        start_level();
        for (int i = 0; i < NL; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            checks++; if (level !== 4'(i + 1)) begin failures++; $display("FAIL win_level_%0d got=%0d exp=%0d", i, level, i + 1); end
            if (i < NL - 1) begin
                checks++; if (state !== 4'd3 || game_won !== 1'b0) begin failures++; $display("FAIL win_state_%0d got st=%0d won=%0d exp 3,0", i, state, game_won); end
                step(1, 0, 0, 0, 0, 0, 0);
                checks++; if (state !== 4'd8) begin failures++; $display("FAIL win_next_%0d got=%0d exp=8", i, state); end
                start_level();
            end
        end
        checks++; if (state !== 4'd9 || game_won !== 1'b1) begin failures++; $display("FAIL win_over got st=%0d won=%0d exp 9,1", state, game_won); end
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (game_won !== 1'b0 || level !== 4'd0) begin failures++; $display("FAIL win_newgame got won=%0d level=%0d exp 0,0", game_won, level); end
        start_level();
        step(0, 0, 0, 0, 0, 1, 1);
        checks++; if (state !== 4'd2 || lives !== 3'd2 || level !== 4'd0) begin failures++; $display("FAIL win_and_fail got st=%0d lives=%0d level=%0d exp 2,2,0", state, lives, level); end
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL fail_sel1_menu got=%0d exp=0", state); end
    endtask

    task automatic test_pause_menu();
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (game_mode !== 1'b1) begin failures++; $display("FAIL endless_mode got=%0d exp=1", game_mode); end
        start_level();
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (state !== 4'd7 || max_option !== 3'd4) begin failures++; $display("FAIL endless_pause got st=%0d max=%0d exp 7,4", state, max_option); end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        checks++; if (select_pos !== 3'd3) begin failures++; $display("FAIL endless_sel got=%0d exp=3", select_pos); end
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (state !== 4'd0 || select_pos !== 3'd0) begin failures++; $display("FAIL endless_menu got st=%0d sel=%0d exp 0,0", state, select_pos); end
        step(1, 0, 0, 0, 0, 0, 0);
        start_level();
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (state !== 4'd7 || max_option !== 3'd3) begin failures++; $display("FAIL classic_pause got st=%0d max=%0d exp 7,3", state, max_option); end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
`ifdef SEL_WRAP_EN
        checks++; if (select_pos !== 3'd0) begin failures++; $display("FAIL classic_sel got=%0d exp=0", select_pos); end
`else
        checks++; if (select_pos !== 3'd2) begin failures++; $display("FAIL classic_sel got=%0d exp=2", select_pos); end
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL classic_menu got=%0d exp=0", state); end
`endif
    endtask

    task automatic test_load_timeout();
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= LT; k++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            if (k == LT - 1) begin
                checks++; if (state !== 4'd4 || load_err !== 1'b0) begin failures++; $display("FAIL tmo_early got st=%0d err=%0d exp 4,0", state, load_err); end
            end
        end
        checks++; if (state !== 4'd8 || load_err !== 1'b1) begin failures++; $display("FAIL tmo_fire got st=%0d err=%0d exp 8,1", state, load_err); end
        step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        checks++; if (state !== 4'd0 || load_err !== 1'b0 || game_mode !== 1'b1) begin failures++; $display("FAIL tmo_rst got st=%0d err=%0d mode=%0d exp 0,0,1", state, load_err, game_mode); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            checks++; if (p_dut !== p_exp) begin failures++; $display("FAIL rnd_pulses cyc=%0d got=%b exp=%b", i, p_dut, p_exp); end
            checks++; if (dvec() !== mvec()) begin failures++; $display("FAIL rnd_regs cyc=%0d got=%h exp=%h", i, dvec(), mvec()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_classic_start();
        test_classic_fail();
        test_classic_win();
        test_pause_menu();
        test_load_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
